// File: rtl/sub_serial_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package sub_serial_pkg;

  localparam int STATE_W       = 2;
  localparam int DEFAULT_WIDTH = 8;

  // Encoding is fixed so a stray value 3 can be recognised and recovered from.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : sub_serial_pkg

// File: rtl/sub_serial_fs_bit.sv
// One-bit full subtractor: d = x - y - bin, bout set when the column underflows.
module fs_bit (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule : fs_bit

// File: rtl/sub_serial.sv
// Bit-serial WIDTH-bit subtractor, out = a - b, one bit per clock, LSB first.
//
// Handshake: in IDLE a clock edge with en=1 loads a/b and starts the operation.
// SUB runs for exactly WIDTH edges with en, a and b ignored. done is high for
// as long as the FSM sits in DONE; out and borrow_out are valid and stable
// there. An edge with en=1 in DONE acknowledges the result and returns to IDLE
// without loading, so a new operation needs a further en edge in IDLE. out and
// borrow_out keep the last result in IDLE until the next load clears them.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_reg_q, a_reg_d;
  logic [WIDTH-1:0] b_reg_q, b_reg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             borrow_q, borrow_d;

  logic             bit_d;
  logic             bit_bout;

  // The single bit cell works on the current LSBs and the running borrow.
  fs_bit u_fs_bit (
    .x    (a_reg_q[0]),
    .y    (b_reg_q[0]),
    .bin  (borrow_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  // State and datapath registers; reset clears everything at once, even mid-operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_reg_q  <= '0;
      b_reg_q  <= '0;
      out_q    <= '0;
      count_q  <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_reg_q  <= a_reg_d;
      b_reg_q  <= b_reg_d;
      out_q    <= out_d;
      count_q  <= count_d;
      borrow_q <= borrow_d;
    end
  end

  // Next-state and datapath updates; every register holds unless its state says otherwise.
  always_comb begin
    state_d  = state_q;
    a_reg_d  = a_reg_q;
    b_reg_d  = b_reg_q;
    out_d    = out_q;
    count_d  = count_q;
    borrow_d = borrow_q;

    case (state_q)
      IDLE: begin
        if (en) begin
          a_reg_d  = a;
          b_reg_d  = b;
          count_d  = '0;
          borrow_d = 1'b0;
          out_d    = '0;
          state_d  = SUB;
        end
      end

      SUB: begin
        out_d    = {bit_d, out_q[WIDTH-1:1]};
        a_reg_d  = a_reg_q >> 1;
        b_reg_d  = b_reg_q >> 1;
        borrow_d = bit_bout;
        // Wraps to 0 on the last edge when WIDTH is a power of two; unused outside SUB.
        count_d  = count_q + 1'b1;
        if (count_q == CNT_LAST) begin
          state_d = DONE;
        end
      end

      DONE: begin
        if (en) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign out        = out_q;
  assign borrow_out = borrow_q;
  assign done       = (state_q == DONE);

endmodule : sub_serial

// File: tb/tb_sub_serial.sv
// Directed and random-operand bench for the bit-serial subtractor (WIDTH=8).
module tb_sub_serial;
  import sub_serial_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] out;
  logic         borrow_out;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {borrow, difference} for each launched operation, oldest first.
  logic [W:0] exp_q[$];
  logic [W:0] last_exp;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sub_serial #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .a          (a),
    .b          (b),
    .out        (out),
    .borrow_out (borrow_out),
    .done       (done)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Launch one operation: en high across exactly one edge in IDLE.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W:0] diff;
    diff = {1'b0, av} - {1'b0, bv};
    exp_q.push_back(diff);
    @(negedge clk);
    a  = av;
    b  = bv;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  // Wait for the remaining SUB edges; done must rise exactly on edge W after the load.
  task automatic wait_done(input string tag, input int edges_seen);
    logic       early;
    logic [W:0] e;
    early = 1'b0;
    for (int k = edges_seen + 1; k < W; k++) begin
      @(posedge clk);
      #1;
      if (done) early = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, " early_done"}, 32'(early), 32'd0);
    check({tag, " done"}, 32'(done), 32'd1);
    if (exp_q.size() == 0) begin
      e = '0;
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
    end
    last_exp = e;
    check({tag, " out"}, 32'(out), 32'(e[W-1:0]));
    check({tag, " borrow"}, 32'(borrow_out), 32'(e[W]));
  endtask

  // Acknowledge the result: done falls after the edge, result stays visible.
  task automatic release_done(input string tag);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    check({tag, " done_fell"}, 32'(done), 32'd0);
    check({tag, " out_held"}, 32'(out), 32'(last_exp[W-1:0]));
    check({tag, " borrow_held"}, 32'(borrow_out), 32'(last_exp[W]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic stable;
    logic [W-1:0] ra, rb;

    rst = 1'b1;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    last_exp = '0;

    // Reset state, checked before the first clock edge.
    #2;
    check("reset out", 32'(out), 32'd0);
    check("reset borrow", 32'(borrow_out), 32'd0);
    check("reset done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: basic subtraction, no borrow.
    start_op(8'h5A, 8'h23);
    wait_done("t1 5A-23", 0);
    release_done("t1");

    // 2: borrow cases and equal operands.
    start_op(8'h10, 8'h20);
    wait_done("t2 10-20", 0);
    release_done("t2a");
    start_op(8'h00, 8'h01);
    wait_done("t2 00-01", 0);
    release_done("t2b");
    start_op(8'hFF, 8'hFF);
    wait_done("t2 FF-FF", 0);
    release_done("t2c");

    // 3: operand changes and en pulses during SUB edges 2-5 must be ignored.
    start_op(8'h80, 8'h01);
    @(posedge clk);
    #1;
    a  = 8'h00;
    b  = 8'hFF;
    en = 1'b1;
    repeat (4) @(posedge clk);
    #1 en = 1'b0;
    wait_done("t3 80-01 disturbed", 5);
    release_done("t3");

    // 4: asynchronous reset between edges in the 4th SUB cycle.
    start_op(8'h5A, 8'h23);
    repeat (3) @(posedge clk);
    #1;
    check("t4 partial out", 32'(out), 32'hE0);
    check("t4 partial borrow", 32'(borrow_out), 32'd1);
    #3 rst = 1'b1;
    #1;
    check("t4 async out", 32'(out), 32'd0);
    check("t4 async borrow", 32'(borrow_out), 32'd0);
    check("t4 async done", 32'(done), 32'd0);
    void'(exp_q.pop_front());
    @(negedge clk);
    rst = 1'b0;
    repeat (W + 2) @(posedge clk);
    #1;
    check("t4 idle after reset", 32'(done), 32'd0);
    start_op(8'h09, 8'h04);
    wait_done("t4 09-04", 0);

    // 5: DONE holds indefinitely with en=0, then acknowledge and run again.
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out !== 8'h05 || borrow_out !== 1'b0 || done !== 1'b1) stable = 1'b0;
    end
    check("t5 done stable", 32'(stable), 32'd1);
    release_done("t5");
    repeat (3) @(posedge clk);
    #1;
    check("t5 idle keeps out", 32'(out), 32'h05);
    start_op(8'h33, 8'h11);
    wait_done("t5 33-11", 0);
    release_done("t5b");

    // 6: random operands with en jitter in IDLE and DONE.
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom_range(0, 255));
      rb = W'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_op(ra, rb);
      wait_done("t6 rand", 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      release_done("t6");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule : tb_sub_serial
